// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - receive-side self-synchronising checker for the 4-bit LFSR pattern
// Optional LFSR_CHK_BITERR_EN adds bit_err_cnt_o, a saturating count of flipped bits in LOCKED.
module lfsr_seq_checker #(
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 3,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           data_i,
    input  logic                 valid_i,
    input  logic                 clr_cnt_i,
    output logic                 locked_o,
    output logic                 err_o,
`ifdef LFSR_CHK_BITERR_EN
    output logic [ERR_CNT_W-1:0] bit_err_cnt_o,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state;
    logic [3:0]    pred;
    logic [MW-1:0] match_cnt;
    logic [LW-1:0] miss_cnt;
    logic          hit;
    logic          bad_locked;

    function automatic logic [3:0] nxt(input logic [3:0] s);
        return {s[2:0], s[1] ^ s[3]};
    endfunction

    assign hit        = (data_i == pred);
    assign bad_locked = valid_i && (state == LOCKED) && !hit;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= SEARCH;
            pred      <= 4'hf;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            if (valid_i) begin
                case (state)
                    SEARCH: begin
                        if (data_i != 4'h0) begin
                            pred      <= nxt(data_i);
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (hit) begin
                            pred <= nxt(pred);
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                locked_o  <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else if (data_i != 4'h0) begin
                            pred      <= nxt(data_i);
                            match_cnt <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // The predictor free-runs here; data never reseeds it once locked.
                        pred <= nxt(pred);
                        if (hit) begin
                            miss_cnt <= '0;
                        end else begin
                            err_o <= 1'b1;
                            if (miss_cnt == LW'(LOSS_CNT - 1)) begin
                                state    <= SEARCH;
                                locked_o <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_cnt_i) begin
            err_cnt_o <= '0;
        end else if (bad_locked && (err_cnt_o != {ERR_CNT_W{1'b1}})) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

`ifdef LFSR_CHK_BITERR_EN
    localparam int SW = (ERR_CNT_W > 3) ? ERR_CNT_W + 1 : 4;

    logic [3:0]    diff;
    logic [2:0]    pop;
    logic [SW-1:0] bit_sum;

    assign diff    = data_i ^ pred;
    assign pop     = 3'(diff[0]) + 3'(diff[1]) + 3'(diff[2]) + 3'(diff[3]);
    assign bit_sum = SW'(bit_err_cnt_o) + SW'(pop);

    always_ff @(posedge clk) begin
        if (!reset || clr_cnt_i) begin
            bit_err_cnt_o <= '0;
        end else if (bad_locked) begin
            if (bit_sum > SW'({ERR_CNT_W{1'b1}}))
                bit_err_cnt_o <= {ERR_CNT_W{1'b1}};
            else
                bit_err_cnt_o <= bit_sum[ERR_CNT_W-1:0];
        end
    end
`endif

endmodule
